// File: rtl/star_scan_scheduler.sv
// star_scan_scheduler: raster-scans the image ROM, triggers the top/bottom finder on uncovered bright pixels
// and records each finder result in a small star table.
module star_scan_scheduler #(
  parameter int XSZ       = 6,
  parameter int YSZ       = 6,
  parameter int X_RES     = 60,
  parameter int Y_RES     = 60,
  parameter int THRESHOLD = 0,
  parameter int MAX_STARS = 8,
  parameter int IDX_SZ    = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  output logic [11:0]       ram_addr,
  input  logic [2:0]        ram_q,
  output logic              star_found,
  output logic [XSZ-1:0]    star_x,
  output logic [YSZ-1:0]    star_y,
  input  logic              tb_found,
  input  logic [YSZ-1:0]    most_top,
  input  logic [YSZ-1:0]    most_bottom,
  input  logic [XSZ-1:0]    mid_x,
  input  logic [IDX_SZ-1:0] rd_idx,
  output logic [YSZ-1:0]    rd_top,
  output logic [YSZ-1:0]    rd_bottom,
  output logic [XSZ-1:0]    rd_mid,
  output logic [IDX_SZ:0]   star_cnt,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              timeout_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [XSZ-1:0] XMAX = XSZ'(X_RES - 1);
  localparam logic [YSZ-1:0] YMAX = YSZ'(Y_RES - 1);
  localparam logic [XSZ:0] HI_MAX = (XSZ + 1)'(X_RES - 1);
  localparam logic [XSZ:0] HI_ONE = (XSZ + 1)'(1);
  typedef enum logic [3:0] {IDLE, ADDR, WAIT, TEST, TRIGGER, WAITFIN, CAPTURE, ADVANCE, DONE} state_t;
  state_t state;
  logic [XSZ-1:0] x;
  logic [YSZ-1:0] y;
  logic [TW-1:0] tmo_cnt;
  logic [YSZ-1:0] t_top [MAX_STARS];
  logic [YSZ-1:0] t_bot [MAX_STARS];
  logic [XSZ-1:0] t_mid [MAX_STARS];
  logic [XSZ-1:0] t_xlo [MAX_STARS];
  logic [MAX_STARS-1:0] hit;
  logic [11:0] addr_nxt;
  logic [IDX_SZ:0] cnt_inc;
  logic covered, bright, last_px;
  // x_hi wraps in XSZ+1 bits before saturating, so a seed right of the mirrored edge clamps to the last column
  for (genvar i = 0; i < MAX_STARS; i++) begin : g_cov
    logic [XSZ:0] x_hi_raw, x_hi;
    assign x_hi_raw = {t_mid[i], 1'b0} + HI_ONE - {1'b0, t_xlo[i]};
    assign x_hi = (x_hi_raw > HI_MAX) ? HI_MAX : x_hi_raw;
    assign hit[i] = ((IDX_SZ + 1)'(i) < star_cnt) && (y >= t_top[i]) && (y <= t_bot[i]) &&
                    (x >= t_xlo[i]) && ({1'b0, x} <= x_hi);
  end
  assign covered = |hit;
  assign bright = ram_q != 3'(THRESHOLD);
  assign last_px = (x == XMAX) && (y == YMAX);
  assign addr_nxt = 12'({y, 5'b0}) + 12'({y, 4'b0}) + 12'({y, 3'b0}) + 12'({y, 2'b0}) + 12'(x);
  assign cnt_inc = star_cnt + (IDX_SZ + 1)'(1);
  assign rd_top = t_top[rd_idx];
  assign rd_bottom = t_bot[rd_idx];
  assign rd_mid = t_mid[rd_idx];
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      tmo_cnt <= '0;
      star_cnt <= '0;
      ram_addr <= '0;
      star_found <= 1'b0;
      star_x <= '0;
      star_y <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      overflow <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < MAX_STARS; i++) begin
        t_top[i] <= '0;
        t_bot[i] <= '0;
        t_mid[i] <= '0;
        t_xlo[i] <= '0;
      end
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state <= ADDR;
          x <= '0;
          y <= '0;
          star_cnt <= '0;
          busy <= 1'b1;
          done <= 1'b0;
          overflow <= 1'b0;
          timeout_err <= 1'b0;
        end
        ADDR: begin
          ram_addr <= addr_nxt;
          state <= WAIT;
        end
        WAIT: state <= TEST;
        TEST: if (bright && !covered) begin
          state <= TRIGGER;
          star_x <= x;
          star_y <= y;
          star_found <= 1'b1;
        end else state <= ADVANCE;
        TRIGGER: begin
          star_found <= 1'b0;
          tmo_cnt <= '0;
          state <= WAITFIN;
        end
        WAITFIN: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          if (tb_found && tmo_cnt >= TW'(2)) state <= CAPTURE;
          else if (tmo_cnt == TW'(TIMEOUT)) begin
            timeout_err <= 1'b1;
            state <= ADVANCE;
          end
        end
        CAPTURE: begin
          t_top[star_cnt[IDX_SZ-1:0]] <= most_top;
          t_bot[star_cnt[IDX_SZ-1:0]] <= most_bottom;
          t_mid[star_cnt[IDX_SZ-1:0]] <= mid_x;
          t_xlo[star_cnt[IDX_SZ-1:0]] <= star_x;
          star_cnt <= cnt_inc;
          if (cnt_inc == (IDX_SZ + 1)'(MAX_STARS) && !last_px) begin
            overflow <= 1'b1;
            done <= 1'b1;
            busy <= 1'b0;
            state <= DONE;
          end else state <= ADVANCE;
        end
        ADVANCE: begin
          x <= (x == XMAX) ? '0 : x + XSZ'(1);
          y <= (x == XMAX) ? y + YSZ'(1) : y;
          if (last_px) begin
            done <= 1'b1;
            busy <= 1'b0;
            state <= DONE;
          end else state <= ADDR;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_star_scan_scheduler.sv
// tb_star_scan_scheduler: table-driven and randomized scans checked against a pixel-level reference scan
module tb_star_scan_scheduler;
  logic clk = 1'b0, resetn = 1'b0, start = 1'b0;
  logic [11:0] ram_addr;
  logic [2:0] ram_q = '0;
  logic star_found;
  logic [5:0] star_x, star_y;
  logic tb_found = 1'b0;
  logic [5:0] most_top = '0, most_bottom = '0, mid_x = '0;
  logic [2:0] rd_idx = '0;
  logic [5:0] rd_top, rd_bottom, rd_mid;
  logic [3:0] star_cnt;
  logic busy, done, overflow, timeout_err;
  int errors = 0, checks = 0;
  logic [2:0] img [3600];
  int fin_delay = 10;
  bit fin_en = 1'b1;
  logic sf_d = 1'b0;
  int f_cnt = 0;
  int obs_x[$], obs_y[$], exp_x[$], exp_y[$];
  int m_top[8], m_bot[8], m_mid[8], m_xlo[8];
  typedef struct {
    int kind; int d; bit en;
    int e_cnt; int e_ovf; int e_tmo; int e_cyc; int e_top; int e_bot; int e_mid;
  } vec_t;
  vec_t vecs[6];

  star_scan_scheduler dut (
    .clk(clk), .resetn(resetn), .start(start), .ram_addr(ram_addr), .ram_q(ram_q),
    .star_found(star_found), .star_x(star_x), .star_y(star_y), .tb_found(tb_found),
    .most_top(most_top), .most_bottom(most_bottom), .mid_x(mid_x), .rd_idx(rd_idx),
    .rd_top(rd_top), .rd_bottom(rd_bottom), .rd_mid(rd_mid), .star_cnt(star_cnt),
    .busy(busy), .done(done), .overflow(overflow), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic bit bright(int x, int y);
    return img[y * 60 + x] != 3'd0;
  endfunction
  function automatic int f_bottom(int x, int y);
    int b = y;
    while (b < 59 && bright(x, b + 1)) b++;
    return b;
  endfunction
  function automatic int f_mid(int x, int y);
    int r = x;
    while (r < 59 && bright(r + 1, y)) r++;
    return (x + r) / 2;
  endfunction

  always @(posedge clk) ram_q <= (int'(ram_addr) < 3600) ? img[ram_addr] : 3'd0;

  // Finder: drops its done level one cycle late (stale) and raises it fin_delay cycles after the trigger edge
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sf_d <= 1'b0;
      f_cnt <= 0;
      tb_found <= 1'b0;
    end else begin
      sf_d <= star_found;
      if (sf_d) begin
        most_top <= star_y;
        most_bottom <= 6'(f_bottom(int'(star_x), int'(star_y)));
        mid_x <= 6'(f_mid(int'(star_x), int'(star_y)));
        tb_found <= 1'b0;
        f_cnt <= fin_en ? fin_delay - 1 : 0;
      end else if (f_cnt != 0) begin
        f_cnt <= f_cnt - 1;
        if (f_cnt == 1) tb_found <= 1'b1;
      end
    end
  end

  always @(negedge clk) if (resetn && star_found) begin
    obs_x.push_back(int'(star_x));
    obs_y.push_back(int'(star_y));
  end

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit m_covered(int x, int y, int n);
    for (int i = 0; i < n; i++) begin
      int hi = (2 * m_mid[i] - m_xlo[i] + 1) & 127;
      if (hi > 59) hi = 59;
      if (y >= m_top[i] && y <= m_bot[i] && x >= m_xlo[i] && x <= hi) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_scan(input int d, input bit en, output int cnt, output int ovf, output int tmo, output int cyc);
    cnt = 0; ovf = 0; tmo = 0; cyc = 0;
    exp_x.delete(); exp_y.delete();
    for (int p = 0; p < 3600; p++) begin
      int x = p % 60, y = p / 60;
      if (!bright(x, y) || m_covered(x, y, cnt)) begin
        cyc += 4;
        continue;
      end
      exp_x.push_back(x); exp_y.push_back(y);
      if (!en) begin
        tmo = 1;
        cyc += 261;
        continue;
      end
      m_top[cnt] = y; m_bot[cnt] = f_bottom(x, y); m_mid[cnt] = f_mid(x, y); m_xlo[cnt] = x;
      cnt++;
      if (cnt == 8 && p != 3599) begin
        ovf = 1;
        cyc += d + 6;
        break;
      end
      cyc += d + 7;
    end
  endtask

  task automatic set_img(int kind);
    foreach (img[i]) img[i] = 3'd0;
    case (kind)
      1: for (int y = 20; y <= 23; y++) for (int x = 10; x <= 14; x++) img[y * 60 + x] = 3'd5;
      2: img[30 * 60 + 30] = 3'd1;
      3: for (int k = 0; k < 9; k++) img[(5 * k + 3) * 60 + 5 * k + 2] = 3'd7;
      4: begin
        for (int k = 0; k < 7; k++) img[(5 * k + 3) * 60 + 5 * k + 2] = 3'd7;
        img[3599] = 3'd2;
      end
      5: for (int r = 0; r < 12; r++) begin
        int x0 = $urandom_range(0, 59), y0 = $urandom_range(0, 59);
        int w = $urandom_range(1, 4), h = $urandom_range(1, 4);
        for (int y = y0; y < y0 + h && y < 60; y++)
          for (int x = x0; x < x0 + w && x < 60; x++) img[y * 60 + x] = 3'($urandom_range(1, 7));
      end
      default: ;
    endcase
  endtask

  task automatic run_vec(int vi);
    int cnt, ovf, tmo, cyc, n;
    vec_t v = vecs[vi];
    set_img(v.kind);
    fin_delay = v.d;
    fin_en = v.en;
    model_scan(v.d, v.en, cnt, ovf, tmo, cyc);
    obs_x.delete(); obs_y.delete();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check($sformatf("v%0d busy after start", vi), int'(busy), 1);
    n = 0;
    while (!done && n < 40000) begin
      @(posedge clk); #1 n++;
      start = (n == 50);
    end
    start = 1'b0;
    check($sformatf("v%0d done", vi), int'(done), 1);
    check($sformatf("v%0d busy at end", vi), int'(busy), 0);
    check($sformatf("v%0d cycles", vi), n, cyc);
    check($sformatf("v%0d star_cnt", vi), int'(star_cnt), cnt);
    check($sformatf("v%0d overflow", vi), int'(overflow), ovf);
    check($sformatf("v%0d timeout_err", vi), int'(timeout_err), tmo);
    check($sformatf("v%0d trigger count", vi), obs_x.size(), exp_x.size());
    for (int i = 0; i < obs_x.size() && i < exp_x.size(); i++) begin
      check($sformatf("v%0d trigger %0d x", vi, i), obs_x[i], exp_x[i]);
      check($sformatf("v%0d trigger %0d y", vi, i), obs_y[i], exp_y[i]);
    end
    for (int i = 0; i < cnt; i++) begin
      rd_idx = 3'(i); #1;
      check($sformatf("v%0d entry %0d top", vi, i), int'(rd_top), m_top[i]);
      check($sformatf("v%0d entry %0d bottom", vi, i), int'(rd_bottom), m_bot[i]);
      check($sformatf("v%0d entry %0d mid", vi, i), int'(rd_mid), m_mid[i]);
    end
    if (v.e_cyc >= 0) begin
      check($sformatf("v%0d cycles table", vi), n, v.e_cyc);
      check($sformatf("v%0d star_cnt table", vi), int'(star_cnt), v.e_cnt);
      check($sformatf("v%0d overflow table", vi), int'(overflow), v.e_ovf);
      check($sformatf("v%0d timeout_err table", vi), int'(timeout_err), v.e_tmo);
    end
    if (v.e_top >= 0) begin
      rd_idx = 3'd0; #1;
      check($sformatf("v%0d entry0 table", vi), {int'(rd_top), int'(rd_bottom), int'(rd_mid)} == {v.e_top, v.e_bot, v.e_mid} ? 1 : 0, 1);
    end
  endtask

  initial begin
    int pulses;
    vecs[0] = '{0, 10, 1'b1, 0, 0, 0, 14400, -1, -1, -1};
    vecs[1] = '{1, 10, 1'b1, 1, 0, 0, 14413, 20, 23, 12};
    vecs[2] = '{2, 10, 1'b0, 0, 0, 1, 14657, -1, -1, -1};
    vecs[3] = '{3, 10, 1'b1, 8, 1, 0, 9375, 3, 3, 2};
    vecs[4] = '{4, 10, 1'b1, 8, 0, 0, 14504, 3, 3, 2};
    vecs[5] = '{5, 2, 1'b1, -1, -1, -1, -1, -1, -1, -1};
    vecs[5].d = $urandom_range(2, 12);
    foreach (img[i]) img[i] = 3'd0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset ram_addr", int'(ram_addr), 0);
    check("reset star_found", int'(star_found), 0);
    check("reset star_xy", int'({star_x, star_y}), 0);
    check("reset star_cnt", int'(star_cnt), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset overflow", int'(overflow), 0);
    check("reset timeout_err", int'(timeout_err), 0);
    rd_idx = 3'd7; #1;
    check("reset table entry", int'({rd_top, rd_bottom, rd_mid}), 0);
    for (int vi = 0; vi < 6; vi++) run_vec(vi);
    // Reset in the middle of waiting for the finder
    foreach (img[i]) img[i] = 3'd0;
    img[1] = 3'd3;
    img[5] = 3'd3;
    fin_en = 1'b1;
    fin_delay = 20;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    pulses = 0;
    for (int c = 0; c < 3000 && pulses < 2; c++) begin
      @(posedge clk); #1;
      if (star_found) pulses++;
    end
    check("second pulse seen", pulses, 2);
    check("star_cnt before reset", int'(star_cnt), 1);
    repeat (3) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check("mid reset star_cnt", int'(star_cnt), 0);
    check("mid reset busy", int'(busy), 0);
    check("mid reset star_found", int'(star_found), 0);
    #3 resetn = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    pulses = 0;
    for (int c = 0; c < 100 && pulses < 1; c++) begin
      @(posedge clk); #1;
      if (star_found) pulses++;
    end
    check("pulse before async reset", int'(star_found), 1);
    #2 resetn = 1'b0;
    #1;
    check("async star_found drop", int'(star_found), 0);
    check("async reset busy", int'(busy), 0);
    #3 resetn = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/star_scan_scheduler.md
Name: star_scan_scheduler

Overview:
- Raster-scans the 60x60 image ROM and, for each bright pixel not already covered by a recorded star, triggers the top/bottom finder.
- Handshake with the finder: a star_found pulse plus the seed x/y coordinates, then a wait for its done level.
- Captures the finder results into a small star table.
- Sits above the top/bottom finder and is the only sequencer of the image ROM read port during scan.

Parameters:
- XSZ, 6, x coordinate width
- YSZ, 6, y coordinate width
- X_RES, 60, image width in pixels
- Y_RES, 60, image height in pixels
- THRESHOLD, 0, pixel value meaning black/background
- MAX_STARS, 8, star table depth
- IDX_SZ, 3, table index width
- TIMEOUT, 255, max cycles to wait for finder done

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a scan from (0,0)
- ram_addr  out  12  image ROM address = y*60 + x
- ram_q  in  3  ROM data, registered, valid 1 cycle after ram_addr
- star_found  out  1  one-cycle pulse to finder
- star_x  out  XSZ  seed x to finder, held stable from trigger through capture
- star_y  out  YSZ  seed y to finder, held stable from trigger through capture
- tb_found  in  1  finder done level
- most_top  in  YSZ  finder result: top row
- most_bottom  in  YSZ  finder result: bottom row
- mid_x  in  XSZ  finder result: horizontal midpoint
- rd_idx  in  IDX_SZ  table read index
- rd_top  out  YSZ  combinational read of entry rd_idx
- rd_bottom  out  YSZ  combinational read of entry rd_idx
- rd_mid  out  XSZ  combinational read of entry rd_idx
- star_cnt  out  IDX_SZ+1  number of valid entries
- busy  out  1  high from the cycle after start until DONE
- done  out  1  level; high in DONE until the next start
- overflow  out  1  sticky; table filled before the scan completed
- timeout_err  out  1  sticky; the finder failed to respond

Behaviour:
- Reset (async): state IDLE; scan x=y=0; star_cnt=0; all table entries 0; star_found, busy, done, overflow, timeout_err = 0; ram_addr=0; star_x=star_y=0.
- start pulse:
  - Accepted only in IDLE or DONE; ignored while busy.
  - On accept: clears x, y, star_cnt, done, overflow, timeout_err.
- A pixel is bright when ram_q != THRESHOLD.
- Each table entry stores top, bottom, mid and x_lo, where x_lo = seed x.
  - Derived x_hi = 2*mid - x_lo + 1, computed 7 bits wide, saturated at X_RES-1.
- A pixel (x,y) is covered if, for any valid entry, top <= y <= bottom and x_lo <= x <= x_hi.
- States:
  - IDLE: start -> ADDR.
  - ADDR: drive ram_addr from (x,y) -> WAIT.
  - WAIT: ROM latency cycle -> TEST.
  - TEST:
    - bright and not covered -> TRIGGER, latching star_x=x and star_y=y.
    - otherwise -> ADVANCE.
  - TRIGGER: star_found=1 for exactly this one cycle -> WAITFIN; clear the timeout counter.
  - WAITFIN: star_found=0; increment the timeout counter each cycle.
    - tb_found=1 and counter >= 2 (ignores stale done) -> CAPTURE.
    - counter == TIMEOUT -> set timeout_err -> ADVANCE; no entry is written.
  - CAPTURE: write {most_top, most_bottom, mid_x, star_x} into entry star_cnt; star_cnt++.
    - star_cnt (after increment) == MAX_STARS and the scan is not finished -> set overflow -> DONE.
    - otherwise -> ADVANCE.
  - ADVANCE:
    - x == X_RES-1: x=0, y++.
    - otherwise: x++.
    - The pixel just tested was x=X_RES-1, y=Y_RES-1 -> DONE.
    - otherwise -> ADDR.
  - DONE: done=1, busy=0; start -> ADDR with cleared state.
- Timing: 4 cycles per non-star pixel; a full empty scan takes 3600*4 = 14400 cycles from start to done.
- Edge cases:
  - A filled table with the last pixel also finishing the scan: DONE without overflow.
  - tb_found asserted while not in WAITFIN: ignored.
  - Reset asserted mid-scan: immediate return to the reset state; star_found drops asynchronously.
- Arithmetic is unsigned throughout.
- ram_addr is computed as y*32 + y*16 + y*8 + y*4 + x, 12 bits.

Test Plan:
- Reset and idle: resetn low for 3 cycles, then high with no start -> all outputs 0, state IDLE, ram_addr=0.
- Empty image (all 0): start -> done rises 14400 cycles later, star_cnt=0, star_found never pulses.
- Single star: bright block x=10..14, y=20..23; finder model returns top=20, bottom=23, mid=12 after 10 cycles.
  - Expect exactly one star_found pulse with star_x=10, star_y=20.
  - Expect entry 0 = {20, 23, 12}, star_cnt=1.
  - The other block pixels are skipped as covered.
- Timeout: finder model never asserts tb_found -> timeout_err=1 after 255 cycles in WAITFIN, scan continues, star_cnt=0.
- Overflow: 9 isolated single-pixel stars -> star_cnt=8, overflow=1, done=1; no 9th star_found pulse.
- Mid-scan controls:
  - Start pulsed while busy -> ignored, scan unaffected.
  - resetn pulsed low mid-WAITFIN -> star_cnt=0, busy=0, and star_found=0 immediately.
